share_encoder: RTL and testbench

SHARE_ENCODER -- requirements
Module: share_encoder

---
 rtl/share_encoder.sv | 131 +++++++++++++
 tb/tb_share_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/share_encoder.sv
// share_encoder: splits x into D Boolean shares, folding in one rin chunk per cycle.
// Optional recombination self-check enabled by SHARE_ENCODER_SELFCHECK_EN.
module share_encoder #(
  parameter int D = 3,
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               EncEnable,
  input  logic [W-1:0]       x,
  input  logic [(D-1)*W-1:0] rin,
  output logic [D*W-1:0]     share_out,
  output logic               EncDone,
  output logic               check_err
);

  localparam int CW = (D > 2) ? $clog2(D) : 1;

  typedef enum logic {IDLE, ACC} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [(D-1)*W-1:0]   rand_q, rand_d;
  logic [D*W-1:0]       share_q, share_d;
  logic                 done_q, done_d;
  logic [W-1:0]         chunk;
  logic [W-1:0]         acc_nx;
  logic                 last;

  // Select the single randomness chunk addressed by the step counter
  always_comb begin
    chunk = '0;
    for (int j = 0; j < D-1; j++) begin
      if (cnt_q == CW'(j)) chunk = rand_q[j*W +: W];
    end
  end

  assign acc_nx = acc_q ^ chunk;
  assign last   = (cnt_q == CW'(D-2));

  // Next-state and output logic: load, one XOR per step, abort or publish
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rand_d  = rand_q;
    share_d = share_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (EncEnable) begin
          acc_d   = x;
          rand_d  = rin;
          cnt_d   = '0;
          state_d = ACC;
        end else begin
          share_d = '0;
        end
      end
      ACC: begin
        if (!EncEnable) begin
          state_d = IDLE;
          share_d = '0;
        end else begin
          acc_d = acc_nx;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            share_d = {acc_nx, rand_q};
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rand_q  <= '0;
      share_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rand_q  <= rand_d;
      share_q <= share_d;
      done_q  <= done_d;
    end
  end

  assign share_out = share_q;
  assign EncDone   = done_q;

`ifdef SHARE_ENCODER_SELFCHECK_EN
  logic [W-1:0] x_q;
  logic [W-1:0] recomb;
  logic         err_q, err_d;

  // Recombine the shares about to be published
  always_comb begin
    recomb = '0;
    for (int i = 0; i < D; i++) begin
      recomb = recomb ^ share_d[i*W +: W];
    end
    err_d = done_d && (recomb != x_q);
  end

  // Keep the loaded plaintext and the mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && EncEnable) x_q <= x;
      err_q <= err_d;
    end
  end

  assign check_err = err_q;
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_share_encoder.sv
// tb_share_encoder: randomized scoreboard bench for share_encoder.
// Expected shares and done times come from a transaction-level model.
module tb_share_encoder;

  localparam int D  = 3;
  localparam int W  = 8;
  localparam int RW = (D-1)*W;
  localparam int SW = D*W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          EncEnable = 1'b0;
  logic [W-1:0]  x = '0;
  logic [RW-1:0] rin = '0;
  logic [SW-1:0] share_out;
  logic          EncDone;
  logic          check_err;

  share_encoder #(.D(D), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EncEnable (EncEnable),
    .x         (x),
    .rin       (rin),
    .share_out (share_out),
    .EncDone   (EncDone),
    .check_err (check_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sh;
    int            at;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            pushed = 0;
  int            popped = 0;
  logic [SW-1:0] visible = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Shares 0..D-2 are the random chunks; the last makes the XOR equal x.
  function automatic logic [SW-1:0] model(input logic [W-1:0] xv,
                                          input logic [RW-1:0] rv);
    logic [SW-1:0] r;
    logic [W-1:0]  m;
    m = xv;
    for (int j = 0; j < D-1; j++) begin
      r[j*W +: W] = rv[j*W +: W];
      m = m ^ rv[j*W +: W];
    end
    r[(D-1)*W +: W] = m;
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_rin();
    logic [RW-1:0] r;
    for (int j = 0; j < D-1; j++) r[j*W +: W] = W'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && EncDone) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sbq.pop_front();
        popped++;
        chk("shares", share_out, mon_e.sh);
        chk("latency", cyc, mon_e.at);
        chk("check_err_done", check_err, 0);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the done negedge
  // with EncEnable still high, or after an abort with EncEnable low.
  task automatic encode(input logic [W-1:0] xv, input logic [RW-1:0] rv,
                        input int abort_k, input bit lit_en,
                        input logic [SW-1:0] lit);
    exp_t e;
    EncEnable = 1'b1;
    x   = xv;
    rin = rv;
    @(posedge clk);
    for (int k = 1; k <= D-1; k++) begin
      @(negedge clk);
      chk("hold", share_out, visible);
      if (k == 1 && abort_k == 0) begin
        e.sh = lit_en ? lit : model(xv, rv);
        e.at = cyc + D - 1;
        sbq.push_back(e);
        pushed++;
      end
      x   = W'($urandom);
      rin = rand_rin();
      if (k == abort_k) begin
        EncEnable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        visible = '0;
        chk("abort_clear", share_out, 0);
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    visible = lit_en ? lit : model(xv, rv);
  endtask

  task automatic idle(input int n);
    EncEnable = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_zero", share_out, 0);
      chk("idle_err", check_err, 0);
    end
    visible = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab;
    repeat (2) @(negedge clk);
    chk("rst_share", share_out, 0);
    chk("rst_done", EncDone, 0);
    chk("rst_err", check_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    encode(8'hA5, {8'h0F, 8'h3C}, 0, 1'b1, 24'h960F3C);
    idle(2);

    encode(8'hA5, {8'h0F, 8'h3C}, 1, 1'b0, '0);
    idle(1);
    encode(8'hA5, {8'h0F, 8'h3C}, 0, 1'b1, 24'h960F3C);
    idle(1);

    encode(8'h00, {8'h22, 8'h11}, 0, 1'b1, 24'h332211);
    encode(8'hFF, {8'h44, 8'h33}, 0, 1'b1, 24'h884433);
    idle(1);

    encode(W'($urandom), rand_rin(), 0, 1'b0, '0);
    EncEnable = 1'b1;
    x   = W'($urandom);
    rin = rand_rin();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_share", share_out, 0);
    chk("midrst_done", EncDone, 0);
    chk("midrst_err", check_err, 0);
    @(negedge clk);
    chk("midrst_hold", share_out, 0);
    rst_n = 1'b1;
    visible = '0;
    idle(1);
    encode(W'($urandom), rand_rin(), 0, 1'b0, '0);
    idle(1);

    for (int i = 0; i < 1000; i++) begin
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, D-1) : 0;
      encode(W'($urandom), rand_rin(), ab, 1'b0, '0);
      if (ab == 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    chk("queue_empty", sbq.size(), 0);
    chk("done_count", popped, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
